conv_channel_acc_param: RTL and testbench

Parametrised cross-channel accumulator for the 3x3 convolution path. It sits after the per-channel convolution core in a conv layer top. It takes per-input-channel partial results streamed channel-planar and sums them per output pixel. It then adds a bias, optionally applies ReLU and stride-2 decimation, and emits one saturated output plane per frame.

---
 rtl/conv_channel_acc_param.sv | 198 +++++++++++++++++++
 tb/tb_conv_channel_acc_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_acc_param.sv
// Cross-channel accumulator: sums channel-planar partial results per pixel,
// then adds bias, optional ReLU, saturation and stride-2 decimation.
module conv_channel_acc_param #(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = 26,
  parameter int IMAGE_WIDTH    = 306,
  parameter int IMAGE_HEIGHT   = 306,
  parameter int CHANNEL_NUM_IN = 256,
  parameter int IMAGE_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] pxl_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  input  logic                         stride2,
  input  logic                         relu_en,
  output logic signed [DATA_WIDTH-1:0] pxl_out,
  output logic                         valid_out,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int AW  = (IMAGE_SIZE > 1)     ? $clog2(IMAGE_SIZE)     : 1;
  localparam int CW  = (IMAGE_WIDTH > 1)    ? $clog2(IMAGE_WIDTH)    : 1;
  localparam int RW  = (IMAGE_HEIGHT > 1)   ? $clog2(IMAGE_HEIGHT)   : 1;
  localparam int CHW = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FIRST, MID, LAST} state_t;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  state_t state, beat_mode, next_mode;
  logic [AW-1:0]  pix_cnt;
  logic [CW-1:0]  col_cnt;
  logic [RW-1:0]  row_cnt;
  logic [CHW-1:0] ch_cnt;
  logic signed [DATA_WIDTH-1:0] bias_reg, frame_bias;
  logic stride_reg, relu_reg, stride_eff, relu_eff, chan_end;

  // The beat that starts a frame is handled with the controls on the pins;
  // later beats use the values captured on that first beat.
  always_comb begin
    beat_mode  = state;
    frame_bias = bias_reg;
    stride_eff = stride_reg;
    relu_eff   = relu_reg;
    if (state == IDLE) begin
      beat_mode  = (CHANNEL_NUM_IN == 1) ? LAST : FIRST;
      frame_bias = bias_in;
      stride_eff = stride2;
      relu_eff   = relu_en;
    end
    chan_end = (pix_cnt == AW'(IMAGE_SIZE - 1));
    case (beat_mode)
      FIRST:   next_mode = (CHANNEL_NUM_IN == 2) ? LAST : MID;
      MID:     next_mode = (ch_cnt == CHW'(CHANNEL_NUM_IN - 2)) ? LAST : MID;
      default: next_mode = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      ch_cnt     <= '0;
      bias_reg   <= '0;
      stride_reg <= 1'b0;
      relu_reg   <= 1'b0;
    end else if (valid_in) begin
      if (state == IDLE) begin
        bias_reg   <= bias_in;
        stride_reg <= stride2;
        relu_reg   <= relu_en;
      end
      if (chan_end) begin
        pix_cnt <= '0;
        col_cnt <= '0;
        row_cnt <= '0;
        ch_cnt  <= (beat_mode == LAST) ? '0 : ch_cnt + 1'b1;
        state   <= next_mode;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
        if (col_cnt == CW'(IMAGE_WIDTH - 1)) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        state <= beat_mode;
      end
    end
  end

  // Stage 1: capture the beat together with the frame controls it belongs to,
  // so a new frame can start while the previous one is still draining.
  state_t s1_mode;
  logic s1_valid, s1_keep, s1_last, s1_relu;
  logic signed [DATA_WIDTH-1:0] s1_pxl, s1_bias;
  logic [AW-1:0] s1_addr;
  logic signed [ACC_WIDTH-1:0] rd_data, s1_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= IDLE;
      s1_pxl   <= '0;
      s1_addr  <= '0;
      s1_keep  <= 1'b0;
      s1_last  <= 1'b0;
      s1_bias  <= '0;
      s1_relu  <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_mode <= beat_mode;
        s1_pxl  <= pxl_in;
        s1_addr <= pix_cnt;
        s1_keep <= !stride_eff || (!row_cnt[0] && !col_cnt[0]);
        s1_last <= chan_end && (beat_mode == LAST);
        s1_bias <= frame_bias;
        s1_relu <= relu_eff;
      end
    end
  end

  always_comb begin
    s1_sum = sext(s1_pxl);
    if (s1_mode != FIRST) s1_sum = rd_data + sext(s1_pxl);
  end

  // A single-channel configuration never needs the accumulator RAM.
  if (CHANNEL_NUM_IN > 1) begin : g_ram
    logic signed [ACC_WIDTH-1:0] acc_mem [IMAGE_SIZE];
    always_ff @(posedge clk) begin
      if (valid_in && beat_mode != FIRST) rd_data <= acc_mem[pix_cnt];
      if (s1_valid && s1_mode != LAST) acc_mem[s1_addr] <= s1_sum;
    end
  end else begin : g_no_ram
    assign rd_data = '0;
  end

  logic s2_valid, s2_keep, s2_last, s2_relu;
  logic signed [ACC_WIDTH-1:0] s2_sum, res, res_relu, res_sat;
  logic signed [DATA_WIDTH-1:0] s2_bias;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_keep  <= 1'b0;
      s2_last  <= 1'b0;
      s2_bias  <= '0;
      s2_relu  <= 1'b0;
    end else begin
      s2_valid <= s1_valid && (s1_mode == LAST);
      s2_sum   <= s1_sum;
      s2_keep  <= s1_keep;
      s2_last  <= s1_last;
      s2_bias  <= s1_bias;
      s2_relu  <= s1_relu;
    end
  end

  always_comb begin
    res      = s2_sum + sext(s2_bias);
    res_relu = (s2_relu && res[ACC_WIDTH-1]) ? '0 : res;
    res_sat  = res_relu;
    if (res_relu > SAT_MAX) res_sat = SAT_MAX;
    if (res_relu < SAT_MIN) res_sat = SAT_MIN;
  end

  // busy only drops at frame end if no new frame has already begun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid_out  <= s2_valid && s2_keep;
      frame_done <= s2_valid && s2_last;
      if (s2_valid && s2_keep) pxl_out <= res_sat[DATA_WIDTH-1:0];
      if (valid_in && state == IDLE) busy <= 1'b1;
      else if (s2_valid && s2_last && state == IDLE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_channel_acc_param.sv
// Bench for conv_channel_acc_param: a 3-channel and a 1-channel 4x2 instance
// checked every cycle against a per-pixel arithmetic model.
module tb_conv_channel_acc_param;

  localparam int W = 4;
  localparam int H = 2;
  localparam int SIZE = W * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid3 = 1'b0, valid1 = 1'b0;
  logic signed [15:0] pxl_in = '0, bias_in = '0;
  logic stride2 = 1'b0, relu_en = 1'b0;
  logic signed [15:0] pxl_out3, pxl_out1;
  logic valid_out3, frame_done3, busy3, valid_out1, frame_done1, busy1;

  int tests = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int due; bit vld; int val; bit done; } exp_t;
  exp_t q3[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_channel_acc_param #(.DATA_WIDTH(16), .ACC_WIDTH(26), .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H), .CHANNEL_NUM_IN(3)) dut3 (
    .clk(clk), .reset(reset), .valid_in(valid3), .pxl_in(pxl_in), .bias_in(bias_in),
    .stride2(stride2), .relu_en(relu_en), .pxl_out(pxl_out3), .valid_out(valid_out3),
    .frame_done(frame_done3), .busy(busy3));

  conv_channel_acc_param #(.DATA_WIDTH(16), .ACC_WIDTH(26), .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H), .CHANNEL_NUM_IN(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid1), .pxl_in(pxl_in), .bias_in(bias_in),
    .stride2(stride2), .relu_en(relu_en), .pxl_out(pxl_out1), .valid_out(valid_out1),
    .frame_done(frame_done1), .busy(busy1));

  // Partial-result generators for the directed patterns.
  function automatic int pix_val(input int kind, input int c, input int p);
    case (kind)
      0:       return p + 10 * c;
      1:       return -20000;
      2:       return 20000;
      default: return p;
    endcase
  endfunction

  // Output of one pixel: channel sum plus bias, then ReLU, then 16-bit saturation.
  function automatic int expect_val(input int kind, input int nch, input int p,
                                    input int bias, input bit relu);
    int s = bias;
    for (int c = 0; c < nch; c++) s += pix_val(kind, c, p);
    if (relu && s < 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one frame (or its first nbeats beats) to one instance and queues the
  // expected output of every final-channel beat.
  task automatic applyStimulus(input bit use1, input int kind, input int bias,
                               input bit stride, input bit relu, input bit gapped,
                               input int nbeats);
    int nch = use1 ? 1 : 3;
    int beats = 0;
    exp_t e;
    for (int c = 0; c < nch; c++) begin
      for (int p = 0; p < SIZE; p++) begin
        if (beats == nbeats) return;
        @(posedge clk); #1;
        if (gapped) begin
          while ($urandom_range(1, 0) == 1) begin
            valid3 = 1'b0; valid1 = 1'b0;
            @(posedge clk); #1;
          end
        end
        valid3  = !use1;
        valid1  = use1;
        pxl_in  = 16'(pix_val(kind, c, p));
        bias_in = (c == 0 && p == 0) ? 16'(bias) : -16'sd999;
        stride2 = (c == 0 && p == 0) ? stride : !stride;
        relu_en = (c == 0 && p == 0) ? relu : !relu;
        if (c == nch - 1) begin
          e.due  = cyc + 3;
          e.vld  = !stride || (((p / W) % 2 == 0) && ((p % W) % 2 == 0));
          e.val  = expect_val(kind, nch, p, bias, relu);
          e.done = (p == SIZE - 1);
          if (use1) q1.push_back(e); else q3.push_back(e);
        end
        beats++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid3 = 1'b0;
      valid1 = 1'b0;
    end
  endtask

  // Every cycle: an output is due exactly when the model says, otherwise silence.
  always @(negedge clk) begin
    exp_t e;
    if (q3.size() > 0 && q3[0].due == cyc) begin
      e = q3.pop_front();
      checkOutput("valid_out3", int'(valid_out3), int'(e.vld));
      checkOutput("frame_done3", int'(frame_done3), int'(e.done));
      if (e.vld) checkOutput("pxl_out3", int'(pxl_out3), e.val);
    end else begin
      checkOutput("quiet_valid3", int'(valid_out3), 0);
      checkOutput("quiet_done3", int'(frame_done3), 0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      checkOutput("valid_out1", int'(valid_out1), int'(e.vld));
      checkOutput("frame_done1", int'(frame_done1), int'(e.done));
      if (e.vld) checkOutput("pxl_out1", int'(pxl_out1), e.val);
    end else begin
      checkOutput("quiet_valid1", int'(valid_out1), 0);
      checkOutput("quiet_done1", int'(frame_done1), 0);
    end
  end

  initial begin
    checkOutput("model_basic_p0", expect_val(0, 3, 0, 5, 1'b0), 35);
    checkOutput("model_basic_p7", expect_val(0, 3, 7, 5, 1'b0), 56);
    checkOutput("model_sat_neg", expect_val(1, 3, 0, 0, 1'b0), -32768);
    checkOutput("model_ch1_p0", expect_val(3, 1, 0, -3, 1'b0), -3);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pxl_out", int'(pxl_out3), 0);
    checkOutput("reset_valid_out", int'(valid_out3), 0);
    checkOutput("reset_frame_done", int'(frame_done3), 0);
    checkOutput("reset_busy", int'(busy3), 0);
    reset = 1'b0;
    idle(2);

    $display("[TB] basic sum");
    applyStimulus(1'b0, 0, 5, 1'b0, 1'b0, 1'b0, 1000);
    @(posedge clk); #1;
    checkOutput("busy_during_drain", int'(busy3), 1);
    valid3 = 1'b0;
    idle(5);
    checkOutput("basic_last_hold", int'(pxl_out3), 56);
    checkOutput("busy_after_frame", int'(busy3), 0);

    $display("[TB] relu and saturation");
    applyStimulus(1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1000);
    idle(5);
    checkOutput("sat_neg_hold", int'(pxl_out3), -32768);
    applyStimulus(1'b0, 1, 0, 1'b0, 1'b1, 1'b0, 1000);
    idle(5);
    checkOutput("relu_hold", int'(pxl_out3), 0);
    applyStimulus(1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 1000);
    idle(5);
    checkOutput("sat_pos_hold", int'(pxl_out3), 32767);

    $display("[TB] stride2");
    applyStimulus(1'b0, 0, 5, 1'b1, 1'b0, 1'b0, 1000);
    idle(5);
    checkOutput("stride_last_hold", int'(pxl_out3), 41);

    $display("[TB] gapped input");
    applyStimulus(1'b0, 0, 5, 1'b0, 1'b0, 1'b1, 1000);
    idle(5);
    checkOutput("gapped_last_hold", int'(pxl_out3), 56);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 0, 9, 1'b0, 1'b0, 1'b0, 12);
    @(posedge clk); #1;
    checkOutput("busy_mid_frame", int'(busy3), 1);
    valid3 = 1'b0;
    reset  = 1'b1;
    #1;
    checkOutput("midreset_pxl_out", int'(pxl_out3), 0);
    checkOutput("midreset_valid_out", int'(valid_out3), 0);
    checkOutput("midreset_busy", int'(busy3), 0);
    q3.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    applyStimulus(1'b0, 0, 5, 1'b0, 1'b0, 1'b0, 1000);
    idle(5);
    checkOutput("post_reset_hold", int'(pxl_out3), 56);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b0, 0, 5, 1'b0, 1'b0, 1'b0, 1000);
    applyStimulus(1'b0, 0, 7, 1'b0, 1'b0, 1'b0, 1000);
    idle(5);
    checkOutput("b2b_last_hold", int'(pxl_out3), 58);
    checkOutput("b2b_busy_after", int'(busy3), 0);

    $display("[TB] single channel");
    applyStimulus(1'b1, 3, -3, 1'b0, 1'b0, 1'b0, 1000);
    idle(5);
    checkOutput("ch1_last_hold", int'(pxl_out1), 4);
    checkOutput("ch1_busy_after", int'(busy1), 0);
    applyStimulus(1'b1, 3, -3, 1'b0, 1'b1, 1'b1, 1000);
    idle(5);

    checkOutput("queue3_drained", q3.size(), 0);
    checkOutput("queue1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
